// File: rtl/fetch_pcselect_if.sv
// ============================================================================
// Module   : fetch_pcselect_if
// Brief    : Single-outstanding instruction-memory request/response handshake
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_pcselect_if;
    logic        ireq;
    logic [31:0] iaddr;
    logic        iaddr_ok;
    logic        idata_ok;
    logic [31:0] idata;

    modport master (
        output ireq,
        output iaddr,
        input  iaddr_ok,
        input  idata_ok,
        input  idata
    );

    modport slave (
        input  ireq,
        input  iaddr,
        output iaddr_ok,
        output idata_ok,
        output idata
    );
endinterface

`default_nettype wire

// File: rtl/fetch_pcselect.sv
// ============================================================================
// Module   : fetch_pcselect
// Brief    : IF-stage PC select and instruction fetch with MIPS delay slots.
//            Optional FETCH_ADEL_CHECK_EN adds misaligned-PC detection (f_adel).
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_pcselect #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        branch_taken,
    input  wire logic        is_jump,
    input  wire logic        is_jr,
    input  wire logic [31:0] pcbranch,
    input  wire logic [31:0] pcjump,
    input  wire logic [31:0] pcjr,
    input  wire logic        exc_valid,
    input  wire logic [31:0] exc_pc,
    input  wire logic        stallF,
    fetch_pcselect_if.master imem,
    output logic             f_valid,
    output logic [31:0]      f_instr,
    output logic [31:0]      f_pc,
    output logic [31:0]      f_pcplus4,
    output logic             fetch_busy
`ifdef FETCH_ADEL_CHECK_EN
    ,
    output logic             f_adel
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_redir_valid;
    logic [31:0] r_redir_pc;
    logic        r_f_valid;
    logic [31:0] r_f_instr;
    logic [31:0] r_f_pc;
    logic [31:0] r_f_pcplus4;
    logic        r_f_adel;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_redir_valid_nxt;
    logic [31:0] w_redir_pc_nxt;
    logic        w_f_valid_nxt;
    logic        w_f_adel_nxt;
    logic        w_cap;
    logic [31:0] w_cap_instr;

    logic        w_misalign;
    logic        w_req;
    logic        w_acc;
    logic        w_redir_any;
    logic [31:0] w_redir_tgt;
    logic [31:0] w_pc_plus4;

`ifdef FETCH_ADEL_CHECK_EN
    assign w_misalign = |r_pc[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_req      = (r_state == S_REQ) && !w_misalign;
    assign w_acc      = w_req && imem.iaddr_ok;

    assign imem.ireq  = w_req && !reset;
    assign imem.iaddr = r_pc;

    assign w_redir_any = is_jr || is_jump || branch_taken;
    assign w_redir_tgt = is_jr   ? pcjr   :
                         is_jump ? pcjump : pcbranch;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_redir_valid_nxt = r_redir_valid;
        w_redir_pc_nxt    = r_redir_pc;
        w_f_valid_nxt     = r_f_valid;
        w_f_adel_nxt      = r_f_adel;
        w_cap             = 1'b0;
        w_cap_instr       = imem.idata;

        if (exc_valid) begin
            w_pc_nxt          = exc_pc;
            w_redir_valid_nxt = 1'b0;
            w_f_valid_nxt     = 1'b0;
            w_f_adel_nxt      = 1'b0;
            // An accepted request still owes us one data beat; drain it first.
            case (r_state)
                S_REQ:   w_state_nxt = (w_acc && !imem.idata_ok) ? S_DRAIN : S_REQ;
                S_WAIT:  w_state_nxt = imem.idata_ok ? S_REQ : S_DRAIN;
                S_HOLD:  w_state_nxt = S_REQ;
                S_DRAIN: w_state_nxt = imem.idata_ok ? S_REQ : S_DRAIN;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            if (w_redir_any) begin
                w_redir_valid_nxt = 1'b1;
                w_redir_pc_nxt    = w_redir_tgt;
            end
            case (r_state)
                S_REQ: begin
                    if (w_misalign) begin
                        w_state_nxt   = S_HOLD;
                        w_cap         = 1'b1;
                        w_cap_instr   = 32'd0;
                        w_f_valid_nxt = 1'b1;
                        w_f_adel_nxt  = 1'b1;
                    end else if (w_acc && imem.idata_ok) begin
                        w_state_nxt   = S_HOLD;
                        w_cap         = 1'b1;
                        w_f_valid_nxt = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.idata_ok) begin
                        w_state_nxt   = S_HOLD;
                        w_cap         = 1'b1;
                        w_f_valid_nxt = 1'b1;
                    end
                end
                S_HOLD: begin
                    // The held instruction is the delay slot; redirects only steer the next PC.
                    if (!stallF) begin
                        w_state_nxt       = S_REQ;
                        w_f_valid_nxt     = 1'b0;
                        w_f_adel_nxt      = 1'b0;
                        w_redir_valid_nxt = 1'b0;
                        w_pc_nxt          = w_redir_any   ? w_redir_tgt :
                                            r_redir_valid ? r_redir_pc  : w_pc_plus4;
                    end
                end
                S_DRAIN: begin
                    if (imem.idata_ok) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= 32'd0;
            r_f_valid     <= 1'b0;
            r_f_instr     <= 32'd0;
            r_f_pc        <= 32'd0;
            r_f_pcplus4   <= 32'd0;
            r_f_adel      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_redir_valid <= w_redir_valid_nxt;
            r_redir_pc    <= w_redir_pc_nxt;
            r_f_valid     <= w_f_valid_nxt;
            r_f_adel      <= w_f_adel_nxt;
            if (w_cap) begin
                r_f_instr   <= w_cap_instr;
                r_f_pc      <= r_pc;
                r_f_pcplus4 <= w_pc_plus4;
            end
        end
    end

    assign f_valid    = r_f_valid;
    assign f_instr    = r_f_instr;
    assign f_pc       = r_f_pc;
    assign f_pcplus4  = r_f_pcplus4;
    assign fetch_busy = !r_f_valid;

`ifdef FETCH_ADEL_CHECK_EN
    assign f_adel = r_f_adel;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_pcselect.md
Name: fetch_pcselect

Overview:
- IF-stage PC selection and instruction fetch unit; consumes the decode stage's branch/jump resolution (branch_taken, is_jump, is_jr, pcbranch, pcjump, pcjr).
- Drives a single-outstanding instruction-memory request handshake.
- Presents fetched instructions (raw_instr, pc, pcplus4) to the F/D pipeline register.
- Honours MIPS delay-slot semantics: a redirect from D never kills the instruction currently in F.

Parameters:
- RESET_PC, 32'hBFC0_0000, first PC fetched after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- branch_taken  in  1  conditional branch resolved taken in D
- is_jump  in  1  J/JAL in D
- is_jr  in  1  JR/JALR in D
- pcbranch  in  32  branch target
- pcjump  in  32  jump target
- pcjr  in  32  register jump target
- exc_valid  in  1  exception/eret redirect; flushes F
- exc_pc  in  32  exception/eret target
- stallF  in  1  hazard unit holds F
- ireq  out  1  instruction request valid
- iaddr  out  32  request address (= pc)
- iaddr_ok  in  1  address accepted this cycle
- idata_ok  in  1  data returned this cycle
- idata  in  32  returned instruction
- f_valid  out  1  f_instr/f_pc valid for F/D register
- f_instr  out  32  fetched instruction
- f_pc  out  32  PC of f_instr
- f_pcplus4  out  32  f_pc + 4
- fetch_busy  out  1  F has no valid instruction; hazard unit stalls

Behaviour:
- Reset (sync, dominates everything): pc=RESET_PC, state=S_REQ, f_valid=0, f_instr=0, f_pc=0, f_pcplus4=0, redir_valid=0, redir_pc=0.
  - ireq is 0 during the reset cycle and 1 in the first cycle after reset.
- States:
  - S_REQ: ireq=1, iaddr=pc. Address held stable until iaddr_ok, except on exception.
  - S_WAIT: ireq=0, waiting for idata_ok.
  - S_HOLD: f_valid=1, instruction held for consumption.
  - S_DRAIN: ireq=0, waiting to discard in-flight data.
- S_REQ transitions:
  - iaddr_ok & idata_ok in the same cycle → capture, go to S_HOLD.
  - iaddr_ok alone → S_WAIT.
- S_WAIT: idata_ok → capture into f_instr/f_pc/f_pcplus4, go to S_HOLD.
- Consume: f_valid & ~stallF. On consume, pc <= redir_valid ? redir_pc : pc+4; redir_valid <= 0; next state S_REQ.
  - Minimum latency, zero-wait memory: 2 cycles per instruction (S_REQ+data, S_HOLD).
- Redirect latch, every cycle with ~exc_valid:
  - Priority: is_jr→pcjr, else is_jump→pcjump, else branch_taken→pcbranch.
  - When any of the three is asserted, redir_valid<=1 and redir_pc<=target. Later assertions overwrite, so repeated pulses from a stalled D are idempotent.
  - A redirect arriving in the same cycle as a consume is applied directly to pc and leaves redir_valid=0.
  - A redirect never discards the in-flight or held instruction (that instruction is the delay slot).
- Exception (exc_valid=1, highest priority):
  - pc<=exc_pc, f_valid<=0, redir_valid<=0.
  - From S_REQ without iaddr_ok, or from S_HOLD → S_REQ.
  - From S_REQ with iaddr_ok → S_DRAIN (single outstanding rule).
  - From S_REQ with iaddr_ok & idata_ok → S_REQ (data dropped).
  - From S_WAIT → S_DRAIN; in the same cycle as idata_ok → S_REQ.
  - S_DRAIN: idata_ok → S_REQ, data dropped. An exception while in S_DRAIN only updates pc.
- fetch_busy = ~f_valid.
- Arithmetic: pc+4 wraps modulo 2^32 with no flag.

Optional Feature:
- Macro: FETCH_ADEL_CHECK_EN
- Enabled: additional output f_adel (1 bit, reset 0).
  - In S_REQ with pc[1:0]≠0: no request (ireq=0); go directly to S_HOLD with f_instr=0, f_adel=1, f_pc=pc.
  - f_adel clears on consume or exception.
- Disabled: no f_adel port. pc[1:0] is ignored; pc+4 and targets are used as given.

Test Plan:
- Reset, memory always ready, idata=PC-derived, no stalls → first ireq with iaddr=BFC00000 in the cycle after reset deassert; f_pc sequence BFC00000, BFC00004, BFC00008, a new f_valid every 2 cycles.
- Branch taken (pcbranch=BFC00100) pulsed while F is in S_WAIT for BFC00008 → f_pc BFC00008 (delay slot) delivered, next iaddr=BFC00100.
- stallF=1 for 5 cycles in S_HOLD with is_jr/pcjr=80001000 repeated every cycle → f_instr held, no ireq; after release exactly one consume, then iaddr=80001000.
- exc_valid with exc_pc=BFC00380 in S_WAIT, idata_ok 3 cycles later → f_valid stays 0, returned data dropped, next iaddr=BFC00380.
- Simultaneous is_jump (pcjump=BFC00200) and branch_taken (pcbranch=BFC00300), then exc_valid in the next cycle → exception wins, next fetch BFC00380, redir_valid=0.
- With FETCH_ADEL_CHECK_EN, pcjr=BFC00102 → no ireq for that PC; f_valid=1, f_adel=1, f_pc=BFC00102, f_instr=0.
